hp35_display_scan: RTL and testbench
====================================

HP35_DISPLAY_SCAN -- requirements
Module: hp35_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 64: PHI2 cycles each digit is held during scan; legal range 2..1024.
REQ-002 Parameter NDIG, default 14: number of display digits captured per word.
REQ-003 PHI2  input  1  global clock; all state changes on the rising edge.
REQ-004 PWO_N  input  1  reset; asynchronous assert, active-low.
REQ-005 DD  input  5  ARC display bus: [3:0] digit code, [4] decimal point.
REQ-006 START  input  1  ARC display start strobe; one-cycle high at bit time 0 of a word.
REQ-007 dig_sel  output  4  index of the digit currently driven (0..NDIG-1).
REQ-008 seg  output  8  segment drive {dp,g,f,e,d,c,b,a}, active-high.
REQ-009 frame_valid  output  1  high once at least one complete word has been committed.
REQ-010 dbg_capt_cnt  output  6  current capture digit counter, for the LA interface.

Function
REQ-011 Capture FSM states: IDLE, CAPT; reset enters IDLE.
REQ-012 IDLE -> CAPT on START=1; bit counter cleared to 0 on that cycle.
REQ-013 In CAPT, bit counter increments every cycle; DD is sampled into shadow[k] when bit counter == 4k+3, k=0..NDIG-1.
REQ-014 After shadow[NDIG-1] is sampled: commit shadow to frame buffer on the next edge, set frame_valid, return to IDLE.
REQ-015 START=1 while in CAPT (early start): discard the partial shadow, no commit, restart capture with bit counter=0.
REQ-016 START coincident with the commit cycle: commit completes and the new capture begins on the same edge.
REQ-017 Frame buffer changes only on commit; the scan never observes a partially captured word.
REQ-018 Scan: prescaler counts 0..SCAN_DIV-1; on wrap, dig_sel advances; dig_sel wraps NDIG-1 -> 0.
REQ-019 seg is registered from frame[dig_sel]: 1 cycle of latency after a dig_sel change; dig_sel and seg change together.
REQ-020 Code map: 0-9 give the decimal glyph; 4'hE gives minus (g only); all other codes are blank; dp=DD[4] captured.
REQ-021 While frame_valid=0, seg=8'h00 and dig_sel still scans.

Reset
REQ-022 On PWO_N low: FSM IDLE, all counters 0, shadow and frame cleared to blank code 4'hF with dp=0, dig_sel=0, seg=0, frame_valid=0.
REQ-023 Reset asserted mid-capture or mid-scan aborts immediately; after release, the first START is required before any capture.
REQ-024 Reset release is synchronised internally with a 2-flop release synchroniser on PHI2.

Configuration
REQ-025 Macro HP35_DISP_7SEG_EN defined: seg carries decoded segments per REQ-020.
REQ-026 Macro HP35_DISP_7SEG_EN undefined: no decoder; seg={dp,3'b000,raw code[3:0]}; REQ-021 blanking still applies.

Structure
REQ-027 Package hp35_pkg holds: NDIG default, word length constant (4 bits/digit), code constants CODE_MINUS=4'hE and CODE_BLANK=4'hF, and the capture state enum.
REQ-028 One sub-module, hp35_seg_decode (combinational code+dp -> 8 segments), instantiated only under HP35_DISP_7SEG_EN.

Verification
REQ-029 START, then DD codes 0..9,E,F,F,F with dp on digit 2 -> after commit, frame_valid=1 and scan shows digit 0 seg=8'h3F, digit 2 seg=8'hDB, digit 10 seg=8'h40, digit 11 seg=8'h00.
REQ-030 START, then 5 digits, then a second START and 14 digits of 8 -> no intermediate commit; all digits seg=8'h7F.
REQ-031 SCAN_DIV=2 -> dig_sel sequence 0,1,...,13,0 with exactly 2 cycles per digit.
REQ-032 PWO_N pulsed low at bit 30 of a capture -> seg=0, frame_valid=0; DD activity with no START causes no commit.
REQ-033 Build without HP35_DISP_7SEG_EN, code 4'h7 with dp -> seg=8'h87.
REQ-034 START on the commit cycle -> old word committed and the following word captured intact.

Source files
------------

// File: rtl/hp35_pkg.sv
// Shared types and constants for the HP-35 display capture/scan block.
// Pure definitions: no logic, no latency, no flow control.
package hp35_pkg;

  localparam int NDIG_DEF     = 14;
  localparam int BITS_PER_DIG = 4;

  localparam logic [3:0] CODE_MINUS = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CAPT = 1'b1
  } capt_state_t;

  // Bit order matches the DD bus: [4] decimal point, [3:0] digit code.
  typedef struct packed {
    logic       dp;
    logic [3:0] code;
  } digit_t;

  localparam digit_t DIGIT_BLANK = '{dp: 1'b0, code: CODE_BLANK};

  function automatic logic [7:0] raw_seg(input digit_t d);
    return {d.dp, 3'b000, d.code};
  endfunction

endpackage

// File: rtl/hp35_seg_decode.sv
// Combinational digit code + dp to {dp,g,f,e,d,c,b,a}; zero latency, no flow control.
// 0-9 decimal glyphs, CODE_MINUS lights g only, every other code is blank.
module hp35_seg_decode
  import hp35_pkg::*;
(
  input  digit_t     i_dig,
  output logic [7:0] o_seg
);

  logic [6:0] w_glyph;

  always_comb begin
    w_glyph = 7'h00;
    case (i_dig.code)
      4'h0:       w_glyph = 7'h3F;
      4'h1:       w_glyph = 7'h06;
      4'h2:       w_glyph = 7'h5B;
      4'h3:       w_glyph = 7'h4F;
      4'h4:       w_glyph = 7'h66;
      4'h5:       w_glyph = 7'h6D;
      4'h6:       w_glyph = 7'h7D;
      4'h7:       w_glyph = 7'h07;
      4'h8:       w_glyph = 7'h7F;
      4'h9:       w_glyph = 7'h6F;
      CODE_MINUS: w_glyph = 7'h40;
      default:    w_glyph = 7'h00;
    endcase
  end

  assign o_seg = {i_dig.dp, w_glyph};

endmodule

// File: rtl/hp35_display_scan.sv
// Captures ARC display words into a frame buffer and multiplexes them; seg/dig_sel lag the scan index by 1 cycle, no backpressure.
// HP35_DISP_7SEG_EN selects decoded segments; otherwise seg carries {dp,000,raw code}.
module hp35_display_scan
  import hp35_pkg::*;
#(
  parameter int SCAN_DIV = 64,
  parameter int NDIG     = NDIG_DEF
) (
  input  logic       PHI2,
  input  logic       PWO_N,
  input  logic [4:0] DD,
  input  logic       START,
  output logic [3:0] dig_sel,
  output logic [7:0] seg,
  output logic       frame_valid,
  output logic [5:0] dbg_capt_cnt
);

  localparam int BIT_W = $clog2(BITS_PER_DIG * NDIG + 1);
  localparam int PRE_W = $clog2(SCAN_DIV);

  localparam logic [BIT_W-1:0] BIT_COMMIT = BIT_W'(BITS_PER_DIG * NDIG);
  localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DIG_MAX    = 4'(NDIG - 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;

  capt_state_t      r_state;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [5:0]       r_capt_cnt;
  digit_t           r_shadow [NDIG];
  digit_t           r_frame  [NDIG];
  logic             r_frame_valid;

  logic [PRE_W-1:0] r_pre;
  logic [3:0]       r_scan_idx;
  logic [3:0]       r_dig_sel;
  logic [7:0]       r_seg;

  logic             w_sample;
  logic             w_commit;
  digit_t           w_cur;
  logic [7:0]       w_seg_dec;

  // Assert asynchronously, release two PHI2 edges after PWO_N rises.
  always_ff @(posedge PHI2 or negedge PWO_N) begin
    if (!PWO_N) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_sample = (r_state == ST_CAPT) && (r_bit_cnt[1:0] == 2'b11) &&
                    (r_bit_cnt < BIT_COMMIT);
  assign w_commit = (r_state == ST_CAPT) && (r_bit_cnt == BIT_COMMIT);

  // A restart leaves stale shadow slots in place: a new word rewrites every
  // slot before it can reach the commit point, so they are never exposed.
  always_ff @(posedge PHI2 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_capt_cnt    <= '0;
      r_frame_valid <= 1'b0;
      for (int k = 0; k < NDIG; k++) begin
        r_shadow[k] <= DIGIT_BLANK;
        r_frame[k]  <= DIGIT_BLANK;
      end
    end else begin
      for (int k = 0; k < NDIG; k++) begin
        if (w_sample && (r_bit_cnt == BIT_W'(BITS_PER_DIG * k + 3))) begin
          r_shadow[k] <= digit_t'(DD);
        end
        if (w_commit) begin
          r_frame[k] <= r_shadow[k];
        end
      end
      if (w_commit) begin
        r_frame_valid <= 1'b1;
      end
      if (w_sample) begin
        r_capt_cnt <= r_capt_cnt + 6'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_state    <= ST_CAPT;
            r_bit_cnt  <= '0;
            r_capt_cnt <= '0;
          end
        end
        ST_CAPT: begin
          if (START) begin
            r_bit_cnt  <= '0;
            r_capt_cnt <= '0;
          end else if (w_commit) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_capt_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_cur = r_frame[r_scan_idx];

`ifdef HP35_DISP_7SEG_EN
  hp35_seg_decode u_seg_decode (
    .i_dig (w_cur),
    .o_seg (w_seg_dec)
  );
`else
  assign w_seg_dec = raw_seg(w_cur);
`endif

  // dig_sel is re-registered next to seg so both outputs move on one edge.
  always_ff @(posedge PHI2 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pre      <= '0;
      r_scan_idx <= '0;
      r_dig_sel  <= '0;
      r_seg      <= '0;
    end else begin
      if (r_pre == PRE_MAX) begin
        r_pre      <= '0;
        r_scan_idx <= (r_scan_idx == DIG_MAX) ? 4'd0 : r_scan_idx + 4'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      r_dig_sel <= r_scan_idx;
      r_seg     <= r_frame_valid ? w_seg_dec : 8'h00;
    end
  end

  assign dig_sel      = r_dig_sel;
  assign seg          = r_seg;
  assign frame_valid  = r_frame_valid;
  assign dbg_capt_cnt = r_capt_cnt;

endmodule

// File: tb/tb_hp35_display_scan.sv
// Self-checking bench for hp35_display_scan: table vectors, corner sequences and
// random words checked against a frame-level reference model.
module tb_hp35_display_scan;

  localparam int NDIG = 14;
  localparam int SDIV = 2;

  logic       PHI2  = 1'b0;
  logic       PWO_N = 1'b0;
  logic       START = 1'b0;
  logic [4:0] DD    = 5'd0;
  logic [3:0] dig_sel;
  logic [7:0] seg;
  logic       frame_valid;
  logic [5:0] dbg_capt_cnt;

  hp35_display_scan #(.SCAN_DIV(SDIV), .NDIG(NDIG)) dut (
    .PHI2         (PHI2),
    .PWO_N        (PWO_N),
    .DD           (DD),
    .START        (START),
    .dig_sel      (dig_sel),
    .seg          (seg),
    .frame_valid  (frame_valid),
    .dbg_capt_cnt (dbg_capt_cnt)
  );

  always #5 PHI2 = ~PHI2;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: the committed word as seen by the display.
  logic [4*NDIG-1:0] m_codes = '0;
  logic [NDIG-1:0]   m_dps   = '0;
  logic              m_valid = 1'b0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 7'h00};

  function automatic logic [7:0] ref_seg(input logic valid, input logic [3:0] code,
                                         input logic dp);
    if (!valid) return 8'h00;
`ifdef HP35_DISP_7SEG_EN
    return {dp, glyph[code]};
`else
    return {dp, 3'b000, code};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_word(input logic [4*NDIG-1:0] codes, input logic [NDIG-1:0] dps,
                            input int n);
    @(negedge PHI2);
    START = 1'b1;
    DD    = 5'($urandom);
    for (int i = 0; i < 4 * n; i++) begin
      @(negedge PHI2);
      START = 1'b0;
      DD    = {dps[i/4], codes[4*(i/4) +: 4]};
    end
  endtask

  task automatic idle_dd(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PHI2);
      START = 1'b0;
      DD    = 5'($urandom);
    end
  endtask

  task automatic commit_word(input logic [4*NDIG-1:0] codes, input logic [NDIG-1:0] dps);
    drive_word(codes, dps, NDIG);
    idle_dd(4);
    m_codes = codes;
    m_dps   = dps;
    m_valid = 1'b1;
  endtask

  task automatic check_digit(input string name, input int d, input logic [7:0] exp);
    bit found = 1'b0;
    for (int c = 0; c < 4 * NDIG * SDIV && !found; c++) begin
      @(posedge PHI2);
      #1;
      if (int'(dig_sel) == d) found = 1'b1;
    end
    if (!found) begin
      n_total++;
      $display("FAIL %s: dig_sel never reached %0d (timeout)", name, d);
    end else begin
      check(name, seg, exp);
    end
  endtask

  task automatic check_scan(input string name, input int cycles);
    int idx;
    for (int c = 0; c < cycles; c++) begin
      @(posedge PHI2);
      #1;
      idx = int'(dig_sel);
      if (idx >= NDIG) check({name, "_idx"}, idx, 0);
      else check(name, seg, ref_seg(m_valid, m_codes[4*idx +: 4], m_dps[idx]));
    end
  endtask

  typedef struct {
    logic [4*NDIG-1:0] codes;
    logic [NDIG-1:0]   dps;
    int                dig;
    logic [7:0]        exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0]        hist [64];
    logic [4*NDIG-1:0] wa, wb;
    logic [NDIG-1:0]   da, db;
    int                i0;
    bit                wrap_seen;

`ifdef HP35_DISP_7SEG_EN
    vecs[0] = '{56'hFFFE9876543210, 14'h0004, 0,  8'h3F};
    vecs[1] = '{56'hFFFE9876543210, 14'h0004, 2,  8'hDB};
    vecs[2] = '{56'hFFFE9876543210, 14'h0004, 10, 8'h40};
    vecs[3] = '{56'hFFFE9876543210, 14'h0004, 11, 8'h00};
    vecs[4] = '{56'hFFFE9876543210, 14'h0004, 9,  8'h6F};
    vecs[5] = '{56'h77777777777777, 14'h0020, 5,  8'h87};
    vecs[6] = '{56'h77777777777777, 14'h0020, 4,  8'h07};
    vecs[7] = '{56'h88888888888888, 14'h0000, 13, 8'h7F};
    vecs[8] = '{56'h88888888888888, 14'h0000, 0,  8'h7F};
`else
    vecs[0] = '{56'hFFFE9876543210, 14'h0004, 0,  8'h00};
    vecs[1] = '{56'hFFFE9876543210, 14'h0004, 2,  8'h82};
    vecs[2] = '{56'hFFFE9876543210, 14'h0004, 10, 8'h0E};
    vecs[3] = '{56'hFFFE9876543210, 14'h0004, 11, 8'h0F};
    vecs[4] = '{56'hFFFE9876543210, 14'h0004, 9,  8'h09};
    vecs[5] = '{56'h77777777777777, 14'h0020, 5,  8'h87};
    vecs[6] = '{56'h77777777777777, 14'h0020, 4,  8'h07};
    vecs[7] = '{56'h88888888888888, 14'h0000, 13, 8'h08};
    vecs[8] = '{56'h88888888888888, 14'h0000, 0,  8'h08};
`endif

    // Reset state
    repeat (3) @(posedge PHI2);
    #1;
    check("rst_dig_sel", dig_sel, 0);
    check("rst_seg", seg, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_capt_cnt", dbg_capt_cnt, 0);
    @(negedge PHI2);
    PWO_N = 1'b1;
    idle_dd(4);

    // Scan cadence with no frame: 2 cycles per digit, wraps 13 -> 0, seg blank
    for (int c = 0; c < 64; c++) begin
      @(posedge PHI2);
      #1;
      hist[c] = dig_sel;
      check("blank_seg", seg, 0);
    end
    i0 = -1;
    for (int c = 1; c < 64 && i0 < 0; c++) if (hist[c] != hist[c-1]) i0 = c;
    if (i0 < 0) begin
      n_total++;
      $display("FAIL scan_advance: dig_sel stuck at %0d, expected it to advance", hist[0]);
    end else begin
      wrap_seen = 1'b0;
      for (int j = i0; j + 2 < 64; j += 2) begin
        check("scan_hold", hist[j+1], hist[j]);
        check("scan_step", hist[j+2], (int'(hist[j]) + 1) % NDIG);
        if (hist[j] == 4'd13 && hist[j+2] == 4'd0) wrap_seen = 1'b1;
      end
      check("scan_wrap_seen", wrap_seen, 1);
    end

    // Early START discards a partial word; no commit in between
    drive_word(56'($urandom) << 24 | 56'($urandom), 14'($urandom), 5);
    @(posedge PHI2);
    #1;
    check("partial_capt_cnt", dbg_capt_cnt, 5);
    check("partial_no_commit", frame_valid, 0);
    commit_word(56'h88888888888888, 14'h0000);
    check("early_frame_valid", frame_valid, 1);
    check_scan("early_restart_seg", 2 * NDIG * SDIV);

    // Table vectors
    for (int v = 0; v < 9; v++) begin
      if (v == 0 || vecs[v].codes != vecs[v-1].codes || vecs[v].dps != vecs[v-1].dps)
        commit_word(vecs[v].codes, vecs[v].dps);
      check_digit($sformatf("vec%0d_dig%0d", v, vecs[v].dig), vecs[v].dig, vecs[v].exp);
    end

    // START on the commit cycle: old word lands, next word captured intact
    wa = {$urandom, $urandom} & 56'hFFFFFFFFFFFFFF;
    da = 14'($urandom);
    wb = {$urandom, $urandom} & 56'hFFFFFFFFFFFFFF;
    db = 14'($urandom);
    drive_word(wa, da, NDIG);
    m_codes = wa;
    m_dps   = da;
    fork
      drive_word(wb, db, NDIG);
      begin
        repeat (6) @(posedge PHI2);
        check_scan("chain_first_word", NDIG * SDIV);
      end
    join
    idle_dd(4);
    m_codes = wb;
    m_dps   = db;
    check_scan("chain_second_word", NDIG * SDIV);

    // Random words, some preceded by an aborted partial capture
    for (int r = 0; r < 6; r++) begin
      wa = {$urandom, $urandom} & 56'hFFFFFFFFFFFFFF;
      da = 14'($urandom);
      if ($urandom_range(0, 1) == 1)
        drive_word({$urandom, $urandom} & 56'hFFFFFFFFFFFFFF, 14'($urandom),
                   $urandom_range(1, NDIG - 1));
      commit_word(wa, da);
      check_scan($sformatf("rand%0d", r), NDIG * SDIV);
    end

    // Reset at bit 30 of a capture; DD traffic without START commits nothing
    drive_word({$urandom, $urandom} & 56'hFFFFFFFFFFFFFF, 14'($urandom), 7);
    idle_dd(3);
    PWO_N = 1'b0;
    @(posedge PHI2);
    #1;
    check("midrst_seg", seg, 0);
    check("midrst_frame_valid", frame_valid, 0);
    check("midrst_dig_sel", dig_sel, 0);
    check("midrst_capt_cnt", dbg_capt_cnt, 0);
    @(negedge PHI2);
    PWO_N   = 1'b1;
    m_valid = 1'b0;
    idle_dd(100);
    check("nostart_frame_valid", frame_valid, 0);
    check_scan("nostart_seg", NDIG * SDIV);

    // Capture works again after the first START following reset
    wa = {$urandom, $urandom} & 56'hFFFFFFFFFFFFFF;
    da = 14'($urandom);
    commit_word(wa, da);
    check("post_rst_frame_valid", frame_valid, 1);
    check_scan("post_rst_seg", NDIG * SDIV);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
